// File: rtl/palette_ram_if.sv
// Bundle of the palette RAM control, write and read signals.
//
// Signals (master drives, slave = palette_ram):
//   init_req  -> one-cycle request to reload the default palette
//   wr_en     -> write strobe
//   wr_addr   -> write index                     [ADDR_W-1:0]
//   wr_data   -> write colour                    [COLOR_W-1:0]
//   rd_addr   -> packed read indices, port i = [i*ADDR_W +: ADDR_W]
//   rd_color  <- packed registered colours, port i = [i*COLOR_W +: COLOR_W]
//   ready     <- palette loaded and accepting writes
//   wr_err    <- one-cycle pulse after a rejected write
//   dbg_state <- FSM state (0 = INIT, 1 = READY) for observation
//
// Write handshake: a write is taken at the rising edge where wr_en=1,
// ready=1 and init_req=0. Any other wr_en=1 cycle is dropped without
// touching memory, and wr_err is high for exactly the following cycle.
// There is no back-pressure; the master must watch ready itself.
interface palette_ram_if #(
  parameter int ADDR_W  = 4,
  parameter int COLOR_W = 8,
  parameter int NPORTS  = 2
);
  logic                        init_req;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [COLOR_W-1:0]          wr_data;
  logic [NPORTS*ADDR_W-1:0]    rd_addr;
  logic [NPORTS*COLOR_W-1:0]   rd_color;
  logic                        ready;
  logic                        wr_err;
  logic                        dbg_state;

  modport master (
    output init_req, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_color, ready, wr_err, dbg_state
  );

  modport slave (
    input  init_req, wr_en, wr_addr, wr_data, rd_addr,
    output rd_color, ready, wr_err, dbg_state
  );
endinterface

// File: rtl/palette_ram.sv
// Multi-port palette RAM with self-loading default colour table.
//
// After reset (or an init_req while READY) the block spends exactly DEPTH
// cycles writing the default table into every entry, then accepts writes.
// Each read port registers memory[rd_addr_i] with one cycle of latency and a
// write-first bypass against the write performed at the same edge.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - palette_ram_if slave modport (see interface file)
module palette_ram #(
  parameter int ADDR_W  = 4,
  parameter int COLOR_W = 8,
  parameter int NPORTS  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  palette_ram_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           cnt_q, cnt_d;
  logic                        wr_err_q, wr_err_d;
  logic [NPORTS*COLOR_W-1:0]   rd_color_q, rd_color_d;

  // Palette storage; contents are fully rewritten by INIT, so no reset.
  logic [COLOR_W-1:0]          mem [DEPTH];

  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_waddr;
  logic [COLOR_W-1:0]          mem_wdata;
  logic [ADDR_W-1:0]           ra;

  // Default 8-bit RRRGGGBB table; zero-extended or cut to the low COLOR_W bits.
  function automatic logic [COLOR_W-1:0] default_color(input logic [ADDR_W-1:0] idx);
    logic [31:0]          i;
    logic [7:0]           v;
    logic [COLOR_W+7:0]   ext;
    i = 32'(idx);
    case (i)
      32'd0:   v = 8'h00;
      32'd1:   v = 8'h02;
      32'd2:   v = 8'h14;
      32'd3:   v = 8'h16;
      32'd4:   v = 8'hA0;
      32'd5:   v = 8'hA2;
      32'd6:   v = 8'hA8;
      32'd7:   v = 8'hB6;
      32'd8:   v = 8'h49;
      32'd9:   v = 8'h4B;
      32'd10:  v = 8'h5D;
      32'd11:  v = 8'h5F;
      32'd12:  v = 8'hE9;
      32'd13:  v = 8'hEB;
      32'd14:  v = 8'hFD;
      32'd15:  v = 8'hFF;
      default: v = 8'h00;
    endcase
    ext = {{COLOR_W{1'b0}}, v};
    return ext[COLOR_W-1:0];
  endfunction

  // Next-state and write-port selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_err_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = default_color(cnt_q);
    case (state_q)
      ST_INIT: begin
        // Loader owns the write port; init_req is ignored, wr_en rejected.
        mem_we   = 1'b1;
        wr_err_d = bus.wr_en;
        if (&cnt_q) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.init_req) begin
          state_d  = ST_INIT;
          cnt_d    = '0;
          wr_err_d = bus.wr_en;
        end else if (bus.wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr;
          mem_wdata = bus.wr_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read ports: zero while loading, otherwise memory with write-first bypass.
  always_comb begin
    rd_color_d = '0;
    ra         = '0;
    if (state_q == ST_READY) begin
      for (int i = 0; i < NPORTS; i++) begin
        ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
        if (mem_we && (ra == mem_waddr)) begin
          rd_color_d[i*COLOR_W +: COLOR_W] = mem_wdata;
        end else begin
          rd_color_d[i*COLOR_W +: COLOR_W] = mem[ra];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      wr_err_q   <= 1'b0;
      rd_color_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_err_q   <= wr_err_d;
      rd_color_q <= rd_color_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ready     = (state_q == ST_READY);
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_color  = rd_color_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/palette_ram.md
PALETTE_RAM -- requirements
Module: palette_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning palette index width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter COLOR_W, default 8, meaning colour word width (RRRGGGBB at 8).
REQ-003 SHALL have parameter NPORTS, default 2, meaning number of independent read ports.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port init_req  input  1  one-cycle request to reload the default palette.
REQ-007 SHALL have port wr_en  input  1  write strobe.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write index.
REQ-009 SHALL have port wr_data  input  COLOR_W  write colour.
REQ-010 SHALL have port rd_addr  input  NPORTS*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_color  output  NPORTS*COLOR_W  packed registered colours; port i = bits [i*COLOR_W +: COLOR_W].
REQ-012 SHALL have port ready  output  1  high when the palette is loaded and accepting writes.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-014 SHALL implement a two-state FSM: INIT and READY.
REQ-015 In INIT, an ADDR_W-bit counter SHALL write default[cnt] into entry cnt each cycle, cnt running 0 to DEPTH-1, then go to READY on the cycle after writing DEPTH-1 (INIT lasts exactly DEPTH cycles).
REQ-016 Default table SHALL be, for entries 0-15: 00,02,14,16,A0,A2,A8,B6,49,4B,5D,5F,E9,EB,FD,FF (hex), zero-extended or LSB-truncated to COLOR_W; entries 16 and above SHALL default to 0.
REQ-017 If DEPTH < 16, only entries 0..DEPTH-1 of the table SHALL be loaded.
REQ-018 ready SHALL be 1 exactly while in READY.
REQ-019 init_req sampled high in READY SHALL enter INIT with cnt=0 on the next cycle; init_req in INIT SHALL be ignored (no restart).
REQ-020 In READY, wr_en=1 SHALL write wr_data to entry wr_addr at the clock edge.
REQ-021 wr_en=1 in INIT, or coincident with init_req in READY, SHALL be dropped (memory unchanged by it) and SHALL pulse wr_err high for the following cycle.
REQ-022 Each read port SHALL register memory[rd_addr_i] so rd_color_i reflects the address sampled at the previous edge (latency 1).
REQ-023 Read of an address written in the same cycle SHALL return the new wr_data (write-first bypass), independently on every port.
REQ-024 All ports SHALL read the same address simultaneously without conflict.
REQ-025 While in INIT, every rd_color_i SHALL be registered as 0.
REQ-026 Addresses are full-range (no out-of-range case exists); cnt wraps to 0 only via re-entry to INIT.

Reset
REQ-027 rst_n low SHALL asynchronously force state INIT, cnt=0, ready=0, wr_err=0, all rd_color=0.
REQ-028 After rst_n rises, the FSM SHALL perform the full DEPTH-cycle INIT before ready asserts.
REQ-029 Reset asserted mid-INIT or mid-write SHALL abort it; the subsequent INIT SHALL restore all defaults, discarding prior writes.
REQ-030 Memory contents SHALL not require reset; correctness derives solely from INIT.

Verification
REQ-031 Defaults: release rst_n, wait 16 cycles (defaults) -> ready=1; read addr 4 on port0, 14 on port1 -> next cycle rd_color = A0 and FD.
REQ-032 Write/read: in READY write addr 3 = 0x3C, next cycle read addr 3 on both ports -> both 0x3C one cycle later.
REQ-033 Bypass: wr_en addr 7 data 0x81 while port1 rd_addr=7 in the same cycle -> port1 = 0x81 next cycle, port0 (addr 0) = 00.
REQ-034 Rejected write: pulse init_req with wr_en addr 2 data 0x55 -> wr_err=1 next cycle, ready=0 for 16 cycles, then addr 2 reads 14.
REQ-035 Reset mid-INIT: assert rst_n low at cnt=5 for 2 cycles -> outputs 0 immediately, ready rises exactly 16 cycles after rst_n release.
REQ-036 Parameter sweep: ADDR_W=5, COLOR_W=12, NPORTS=3 -> entry 1 reads 0x002, entry 20 reads 0x000, three ports return independent values.
